// File: rtl/conv_stream_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : conv_stream_driver
//  Purpose  : Host-loaded x source and y sink around a conv_* engine:
//             streams LENX samples out over valid/ready, then captures
//             LENY = LENX-LENF+1 results for registered readback.
//  Revision : 1.0  initial release
// ============================================================================
module conv_stream_driver #(
    parameter int WIDTH = 32,
    parameter int LENX  = 43,
    parameter int LENF  = 16,
    parameter int ADDRX = 6,
    parameter int ADDRY = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_wr_en,
    input  logic [ADDRX-1:0] h_addr,
    input  logic [WIDTH-1:0] h_data,
    input  logic             start,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    input  logic             y_hold,
    input  logic [ADDRY-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam int               c_LENY     = LENX - LENF + 1;
    localparam logic [ADDRX-1:0] c_TX_LAST  = ADDRX'(LENX - 1);
    localparam logic [ADDRY-1:0] c_RX_LAST  = ADDRY'(c_LENY - 1);
    localparam logic [ADDRX:0]   c_LENX_EXT = (ADDRX + 1)'(LENX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREF = 2'd1,
        ST_SEND = 2'd2,
        ST_RECV = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_xbuf [LENX];
    logic [WIDTH-1:0] r_ybuf [2**ADDRY];
    logic [ADDRX-1:0] r_tx_idx;
    logic [ADDRY-1:0] r_rx_idx;
    logic [WIDTH-1:0] r_data_x;
    logic             r_valid_x;
    logic             r_recv;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_x_hs;
    logic             w_y_hs;
    logic             w_host_wr;
    logic [ADDRX-1:0] w_tx_next;

    assign w_x_hs    = r_valid_x & m_ready_x;
    assign w_y_hs    = r_recv & ~y_hold & s_valid_y;
    assign w_host_wr = h_wr_en & (r_state == ST_IDLE) & ({1'b0, h_addr} < c_LENX_EXT);
    assign w_tx_next = r_tx_idx + 1'b1;

    // x buffer is frozen outside IDLE so the read-ahead path never races a write
    always_ff @(posedge clk) begin
        if (w_host_wr) begin
            r_xbuf[h_addr] <= h_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_y_hs) begin
            r_ybuf[r_rx_idx] <= s_data_in_y;
        end
    end

    // Non-blocking read gives old data on a same-cycle write to the same address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_ybuf[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_tx_idx  <= '0;
            r_rx_idx  <= '0;
            r_data_x  <= '0;
            r_valid_x <= 1'b0;
            r_recv    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_PREF;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_tx_idx <= '0;
                        r_rx_idx <= '0;
                    end
                end
                ST_PREF: begin
                    r_data_x  <= r_xbuf[r_tx_idx];
                    r_valid_x <= 1'b1;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_x_hs) begin
                        r_tx_idx <= w_tx_next;
                        if (r_tx_idx == c_TX_LAST) begin
                            r_valid_x <= 1'b0;
                            r_recv    <= 1'b1;
                            r_state   <= ST_RECV;
                        end else begin
                            // read-ahead keeps the stream bubble-free
                            r_data_x <= r_xbuf[w_tx_next];
                        end
                    end
                end
                ST_RECV: begin
                    if (w_y_hs) begin
                        r_rx_idx <= r_rx_idx + 1'b1;
                        if (r_rx_idx == c_RX_LAST) begin
                            r_recv  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_data_out_x = r_data_x;
    assign m_valid_x    = r_valid_x;
    assign s_ready_y    = r_recv & ~y_hold;
    assign rd_data      = r_rd_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv_stream_driver
//  Purpose  : Self-checking bench for conv_stream_driver (run table, random
//             handshakes against a transaction-level model, readback table).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_stream_driver;

    localparam int WIDTH = 32;
    localparam int LENX  = 43;
    localparam int LENF  = 16;
    localparam int ADDRX = 6;
    localparam int ADDRY = 5;
    localparam int LENY  = LENX - LENF + 1;

    localparam int P_PREF = 1;
    localparam int P_SEND = 2;
    localparam int P_RECV = 3;
    localparam int P_DONE = 4;

    logic             clk;
    logic             reset;
    logic             h_wr_en;
    logic [ADDRX-1:0] h_addr;
    logic [WIDTH-1:0] h_data;
    logic             start;
    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x;
    logic [WIDTH-1:0] s_data_in_y;
    logic             s_valid_y;
    logic             s_ready_y;
    logic             y_hold;
    logic [ADDRY-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;

    conv_stream_driver #(
        .WIDTH(WIDTH), .LENX(LENX), .LENF(LENF), .ADDRX(ADDRX), .ADDRY(ADDRY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .h_wr_en      (h_wr_en),
        .h_addr       (h_addr),
        .h_data       (h_data),
        .start        (start),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .y_hold       (y_hold),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rmode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
        int ymode;   // 0 always valid, 1 hold 10 cycles with -5, 2 random
        int inject;  // pulse start/h_wr_en mid-run
        int reload;  // 0 keep, 1 x=i+1, 2 random
        int exp_tx;
        int exp_rx;
    } run_cfg_t;

    typedef struct {
        logic [ADDRY-1:0] addr;
        logic [WIDTH-1:0] exp;
    } rb_vec_t;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mx [LENX];
    logic [WIDTH-1:0] my [LENY];
    logic [WIDTH-1:0] yq [LENY];
    bit               pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load_x(input int kind);
        for (int i = 0; i < LENX; i++) begin
            mx[i] = (kind == 1) ? 32'(i + 1) : $urandom;
            @(posedge clk); #1;
            h_wr_en = 1'b1;
            h_addr  = ADDRX'(i);
            h_data  = mx[i];
        end
        @(posedge clk); #1;
        h_wr_en = 1'b0;
    endtask

    task automatic readback(input logic [ADDRY-1:0] a, input logic [WIDTH-1:0] exp);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check("rd_data", rd_data, exp);
    endtask

    // Transaction-level model: x must arrive in buffer order, one sample per
    // accepted beat; y is accepted only in the receive phase and not while held.
    task automatic run(input int rmode, input int ymode, input int inject, input int abort_at,
                       output int hx_n, output int hy_n, output int send_cyc);
        int  tx = 0;
        int  rx = 0;
        int  hold = 0;
        int  ph;
        bit  fin = 1'b0;
        bit  injected = 1'b0;
        hx_n = 0; hy_n = 0; send_cyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ph = P_PREF;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (abort_at > 0 && ph == P_SEND && tx == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check_bit("abort_m_valid_x", m_valid_x, 1'b0);
                check_bit("abort_busy", busy, 1'b0);
                check_bit("abort_done", done, 1'b0);
                check_bit("abort_s_ready_y", s_ready_y, 1'b0);
                check("abort_m_data_out_x", m_data_out_x, '0);
                check("abort_rd_data", rd_data, '0);
                #3 reset = 1'b1;
                return;
            end
            case (rmode)
                0:       m_ready_x = 1'b1;
                1:       m_ready_x = pat[send_cyc % 4];
                default: m_ready_x = 1'($urandom_range(0, 1));
            endcase
            case (ymode)
                0: begin s_valid_y = 1'b1; y_hold = 1'b0; end
                1: begin s_valid_y = 1'b1; y_hold = (ph == P_RECV) && (hold < 10); end
                default: begin
                    s_valid_y = 1'($urandom_range(0, 1));
                    y_hold    = ($urandom_range(0, 3) == 0);
                end
            endcase
            s_data_in_y = (rx < LENY) ? yq[rx] : '0;
            start   = 1'b0;
            h_wr_en = 1'b0;
            if (inject != 0 && ph == P_SEND && tx == 5 && !injected) begin
                start = 1'b1; h_wr_en = 1'b1; h_addr = '0; h_data = 32'd999;
                injected = 1'b1;
            end else if (inject != 0 && ph == P_RECV && rx == LENY - 1) begin
                start = 1'b1;
            end
            @(negedge clk);
            check_bit("busy", busy, ph != P_DONE);
            check_bit("done", done, ph == P_DONE);
            check_bit("m_valid_x", m_valid_x, ph == P_SEND);
            if (ph == P_SEND) check("m_data_out_x", m_data_out_x, mx[tx]);
            check_bit("s_ready_y", s_ready_y, (ph == P_RECV) && !y_hold);
            if (ph == P_DONE) begin
                fin = 1'b1;
                break;
            end
            if (m_valid_x && m_ready_x) hx_n++;
            if (s_valid_y && s_ready_y) hy_n++;
            case (ph)
                P_PREF: ph = P_SEND;
                P_SEND: begin
                    send_cyc++;
                    if (m_ready_x) begin
                        tx++;
                        if (tx == LENX) ph = P_RECV;
                    end
                end
                P_RECV: begin
                    hold++;
                    if (s_valid_y && !y_hold) begin
                        my[rx] = yq[rx];
                        rx++;
                        if (rx == LENY) ph = P_DONE;
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_bit("run_finished", fin, 1'b1);
    endtask

    run_cfg_t cfgs [8];
    rb_vec_t  rb   [LENY];

    initial begin
        int hx, hy, sc;
        cfgs[0] = '{0, 0, 0, 1, LENX, LENY};
        cfgs[1] = '{1, 0, 0, 0, LENX, LENY};
        cfgs[2] = '{0, 1, 0, 0, LENX, LENY};
        cfgs[3] = '{0, 0, 1, 0, LENX, LENY};
        cfgs[4] = '{0, 0, 0, 0, LENX, LENY};
        cfgs[5] = '{2, 2, 0, 2, LENX, LENY};
        cfgs[6] = '{2, 2, 0, 0, LENX, LENY};
        cfgs[7] = '{2, 2, 0, 2, LENX, LENY};
        for (int k = 0; k < LENY; k++) rb[k] = '{ADDRY'(k), 32'(100 + k)};

        reset = 1'b0; h_wr_en = 1'b0; h_addr = '0; h_data = '0; start = 1'b0;
        m_ready_x = 1'b0; s_data_in_y = '0; s_valid_y = 1'b0; y_hold = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_m_valid_x", m_valid_x, 1'b0);
        check_bit("rst_s_ready_y", s_ready_y, 1'b0);
        check("rst_m_data_out_x", m_data_out_x, '0);
        check("rst_rd_data", rd_data, '0);
        #2 reset = 1'b1;

        for (int r = 0; r < 8; r++) begin
            if (cfgs[r].reload == 1) load_x(1);
            else if (cfgs[r].reload == 2) load_x(2);
            for (int k = 0; k < LENY; k++) yq[k] = (r == 0) ? 32'(100 + k) : $urandom;
            if (cfgs[r].ymode == 1) yq[0] = 32'hFFFF_FFFB;
            run(cfgs[r].rmode, cfgs[r].ymode, cfgs[r].inject, 0, hx, hy, sc);
            check("x_handshakes", 32'(hx), 32'(cfgs[r].exp_tx));
            check("y_handshakes", 32'(hy), 32'(cfgs[r].exp_rx));
            if (cfgs[r].rmode == 0) check("send_cycles", 32'(sc), 32'(LENX));
            if (r == 0) begin
                for (int k = 0; k < LENY; k++) readback(rb[k].addr, rb[k].exp);
            end else begin
                for (int k = 0; k < LENY; k++) readback(ADDRY'(k), my[k]);
            end
        end

        load_x(1);
        for (int k = 0; k < LENY; k++) yq[k] = $urandom;
        run(0, 0, 0, 20, hx, hy, sc);
        repeat (2) @(posedge clk);
        load_x(2);
        for (int k = 0; k < LENY; k++) yq[k] = $urandom;
        run(2, 2, 0, 0, hx, hy, sc);
        check("post_reset_x_handshakes", 32'(hx), 32'(LENX));
        for (int k = 0; k < LENY; k++) readback(ADDRY'(k), my[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
